uart_io_port: RTL and testbench
===============================

Name: uart_io_port

Overview:
- UART peripheral on the processor IO port bus; the device side answering `processor_top` IO reads and writes.
- Port 01: write = TX byte into a FIFO, read = RX byte. Port 02: RX-data-present status. Port 03: TX-full status. Port 04: error flags.
- Serialises TX bytes onto `uart_txd` and deserialises `uart_rxd` into a one-byte holding register. Frame format is 8N1, LSB first.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- BAUD, 115200, line rate. Bit period DIV = CLK_HZ/BAUD, integer-truncated; DIV >= 4 is required.
- TX_DEPTH, 4, TX FIFO entries; power of two, >= 2.

Ports:
- `clk100` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-low (0 = reset).
- `IO_port_ID` input 8: port address, valid while either strobe is high.
- `IO_write_data` input 8: write data.
- `IO_write_strobe` input 1: one-cycle write qualifier.
- `IO_read_strobe` input 1: one-cycle read qualifier.
- `IO_read_data` output 8: read data, combinational.
- `uart_rxd` input 1: asynchronous serial input.
- `uart_txd` output 1: serial output, idle high.

Behaviour:
- **Reset** (reset=0 at an edge):
  - TX FIFO empty, TX FSM IDLE, `uart_txd`=1.
  - RX FSM IDLE, rx_valid=0, rx_byte=0, overrun=0, framing=0.
  - Both sync flops = 1.
  - Reset mid-frame abandons the frame immediately; `uart_txd` goes high on the next edge.
- **Read mux**:
  - `IO_read_data` = 8'h00 while `IO_read_strobe`=0.
  - While `IO_read_strobe`=1:
    - 01: rx_byte if rx_valid, else 8'h00.
    - 02: 8'hFF if rx_valid, else 8'h00.
    - 03: 8'hFF if the FIFO is full, else 8'h00.
    - 04: {6'b0, framing, overrun}.
    - Any other port: 8'hFF.
- **Read side effects**, applied at the clock edge where the strobe is high:
  - Port 01 clears rx_valid.
  - Port 04 clears both error flags.
  - Reads of ports 02 and 03 have no side effect.
- **Writes**:
  - Port 01 with the FIFO not full pushes `IO_write_data`.
  - Port 01 with the FIFO full drops the byte, even if the TX FSM pops in the same cycle. Fullness is evaluated pre-edge.
  - Writes to other ports are ignored.
  - Both strobes high in one cycle: each is handled independently.
- **TX FSM** (states IDLE, START, DATA, STOP; DIV-cycle bit counter, 3-bit index):
  - IDLE with FIFO not empty: pop, load the shifter, go to START, `uart_txd`=0 from the next edge.
  - Each bit is held exactly DIV cycles. DATA sends bit0..bit7. STOP drives 1 for DIV cycles.
  - From STOP, go to IDLE. If the FIFO is non-empty, the next START begins on the following cycle, giving a frame-to-frame gap of DIV+1 cycles from stop-bit start.
  - The FIFO is a circular buffer with wrapping pointers and a count register.
- **RX path**: `uart_rxd` passes through a 2-flop synchroniser; rxs is the second flop. RX FSM states are IDLE, START, DATA, STOP.
  - IDLE: rxs=0 goes to START and loads counter = DIV/2 − 1.
  - START: at counter expiry, rxs=1 is a glitch and returns to IDLE with no flag; rxs=0 goes to DATA.
  - DATA: sample every DIV cycles into bit0..bit7.
  - STOP: sample after DIV cycles.
  - Stop=1, rx_valid=0: load rx_byte, set rx_valid.
  - Stop=1, rx_valid=1: set overrun, keep the old rx_byte, discard the new byte.
  - Stop=0: set framing, discard the byte.
  - After STOP, return to IDLE immediately. A line held low re-enters START (break is reported as repeated framing errors).
  - Completion in the same edge as a port-01 read: the read clears the old byte, the new byte loads, rx_valid stays 1, no overrun.
- **Flag priority**: a set event and a clear-on-read in the same cycle leave the flag set.

Decomposition:
- Package `uart_io_pkg`:
  - Port ID constants 8'h01–8'h04.
  - STAT_TRUE=8'hFF, STAT_FALSE=8'h00, UNMAPPED=8'hFF.
  - Enum `uart_state_t` {IDLE, START, DATA, STOP}, shared by the TX and RX FSMs.
- One sub-module `uart_tx_fifo`:
  - Parameter DEPTH; push/pop/full/empty/dout.
  - The push-when-full drop rule lives here.
- The RX FSM, TX FSM and read mux stay in the top level.

Test Plan (CLK_HZ=100_000_000, BAUD=10_000_000, so DIV=10):
- TX single byte: write 8'hA5 to port 01 → `uart_txd` low 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10; port 03 reads 8'h00 throughout.
- FIFO full/drop: 5 back-to-back writes 8'h01..8'h05 on consecutive cycles:
  - Cycle 1: 8'h01 is pushed and immediately popped by the idle TX FSM.
  - Cycles 2–5: 8'h02..8'h05 are pushed and the FIFO is full after cycle 5, so port 03 reads 8'hFF.
  - A sixth write 8'h06 while full is dropped.
  - Line carries exactly 01,02,03,04,05, with start bits 101 cycles apart.
- RX + status: drive frame 8'h3C on `uart_rxd` → port 02 reads 8'hFF, port 01 returns 8'h3C, the next port 02 read returns 8'h00.
- Overrun/framing:
  - Send 8'h11 then 8'h22 without reading → port 01 = 8'h11, port 04 = 8'h01 then 8'h00.
  - Send a frame with stop bit 0 → port 04 = 8'h02, rx_valid stays 0.
- Glitch + unmapped: rxd low for 3 cycles only → no byte, no flags. Read port 8'h07 → 8'hFF. Strobe low → 8'h00.
- Reset mid-frame: assert reset=0 during TX bit 4 → `uart_txd`=1 next edge; FIFO empty; port 03 reads 8'h00 after release.

Source files
------------

// File: rtl/uart_io_pkg.sv
// uart_io_pkg: shared constants and types for the UART IO-port peripheral.
//   - Port IDs decoded on the processor IO bus.
//   - Status byte encodings returned by the read mux.
//   - Line FSM state type shared by the TX and RX serial engines.
package uart_io_pkg;

  localparam logic [7:0] PORT_DATA    = 8'h01;  // write: TX byte, read: RX byte
  localparam logic [7:0] PORT_RX_STAT = 8'h02;  // RX data present
  localparam logic [7:0] PORT_TX_STAT = 8'h03;  // TX FIFO full
  localparam logic [7:0] PORT_ERR     = 8'h04;  // {6'b0, framing, overrun}

  localparam logic [7:0] STAT_TRUE  = 8'hFF;
  localparam logic [7:0] STAT_FALSE = 8'h00;
  localparam logic [7:0] UNMAPPED   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_io_port_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding the UART transmitter.
// Ports:
//   clk, reset (sync, active-low)
//   push/din   : enqueue request; silently dropped when full (fullness is pre-edge,
//                so a same-cycle pop never makes room for the push)
//   pop        : dequeue request; ignored when empty
//   dout       : head entry, valid while !empty
//   full/empty : occupancy flags derived from the count register
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage write; data needs no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_io_port.sv
// uart_io_port: 8N1 UART on the processor IO port bus.
// Ports:
//   clk100          : system clock, rising edge
//   reset           : synchronous, active-low
//   IO_port_ID      : port address (01 data, 02 RX status, 03 TX full, 04 errors)
//   IO_write_data   : write data, IO_write_strobe qualifies it
//   IO_read_strobe  : read qualifier; reads of 01/04 clear rx_valid / error flags
//   IO_read_data    : combinational read mux, 8'h00 while no read strobe
//   uart_rxd        : asynchronous serial input
//   uart_txd        : serial output, idle high, driven from a flop
module uart_io_port #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 4
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  import uart_io_pkg::*;

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic       wr_data_s;
  logic       rd_data_s;
  logic       rd_err_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic [7:0] fifo_dout_s;

  assign wr_data_s = IO_write_strobe & (IO_port_ID == PORT_DATA);
  assign rd_data_s = IO_read_strobe & (IO_port_ID == PORT_DATA);
  assign rd_err_s  = IO_read_strobe & (IO_port_ID == PORT_ERR);

  // ---------------------------------------------------------------- TX path
  uart_state_t tx_state_r, tx_state_s;
  logic [CW-1:0] tx_cnt_r, tx_cnt_s;
  logic [2:0]    tx_idx_r, tx_idx_s;
  logic [7:0]    tx_shift_r, tx_shift_s;
  logic          tx_line_r, tx_line_s;
  logic          tx_pop_s;

  uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk   (clk100),
    .reset (reset),
    .push  (wr_data_s),
    .din   (IO_write_data),
    .pop   (tx_pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // TX next-state: the shifter's bit0 is always the bit currently on the line.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_idx_s   = tx_idx_r;
    tx_shift_s = tx_shift_r;
    tx_line_s  = tx_line_r;
    tx_pop_s   = 1'b0;
    case (tx_state_r)
      IDLE: begin
        tx_line_s = 1'b1;
        if (!fifo_empty_s) begin
          tx_pop_s   = 1'b1;
          tx_shift_s = fifo_dout_s;
          tx_cnt_s   = BIT_LAST;
          tx_idx_s   = 3'd0;
          tx_line_s  = 1'b0;
          tx_state_s = START;
        end else begin
          tx_state_s = IDLE;
        end
      end
      START: begin
        if (tx_cnt_r == CNT_ZERO) begin
          tx_cnt_s   = BIT_LAST;
          tx_line_s  = tx_shift_r[0];
          tx_state_s = DATA;
        end else begin
          tx_cnt_s = tx_cnt_r - CNT_ONE;
        end
      end
      DATA: begin
        if (tx_cnt_r == CNT_ZERO) begin
          tx_cnt_s = BIT_LAST;
          if (tx_idx_r == 3'd7) begin
            tx_line_s  = 1'b1;
            tx_state_s = STOP;
          end else begin
            tx_idx_s   = tx_idx_r + 3'd1;
            tx_line_s  = tx_shift_r[1];
            tx_shift_s = {1'b0, tx_shift_r[7:1]};
          end
        end else begin
          tx_cnt_s = tx_cnt_r - CNT_ONE;
        end
      end
      STOP: begin
        // Returning through IDLE costs one cycle: next start is DIV+1 after stop start.
        if (tx_cnt_r == CNT_ZERO) begin
          tx_state_s = IDLE;
        end else begin
          tx_cnt_s = tx_cnt_r - CNT_ONE;
        end
      end
      default: begin
        tx_state_s = IDLE;
        tx_line_s  = 1'b1;
      end
    endcase
  end

  // TX state register; reset abandons any frame and returns the line high.
  always_ff @(posedge clk100) begin
    if (!reset) begin
      tx_state_r <= IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_idx_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx_line_r  <= 1'b1;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_idx_r   <= tx_idx_s;
      tx_shift_r <= tx_shift_s;
      tx_line_r  <= tx_line_s;
    end
  end

  assign uart_txd = tx_line_r;

  // ---------------------------------------------------------------- RX path
  logic rx_sync1_r, rx_sync2_r;
  uart_state_t rx_state_r, rx_state_s;
  logic [CW-1:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]    rx_idx_r, rx_idx_s;
  logic [7:0]    rx_shift_r, rx_shift_s;
  logic          rx_done_s;
  logic          rx_stop_s;
  logic [7:0]    rx_byte_r;
  logic          rx_valid_r;
  logic          overrun_r;
  logic          framing_r;
  logic          rx_load_s;
  logic          ovr_set_s;
  logic          frm_set_s;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk100) begin
    if (!reset) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
    end else begin
      rx_sync1_r <= uart_rxd;
      rx_sync2_r <= rx_sync1_r;
    end
  end

  // RX next-state: half-bit wait lands later samples mid-bit; data shifts in LSB first.
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_idx_s   = rx_idx_r;
    rx_shift_s = rx_shift_r;
    rx_done_s  = 1'b0;
    rx_stop_s  = 1'b0;
    case (rx_state_r)
      IDLE: begin
        if (!rx_sync2_r) begin
          rx_cnt_s   = HALF_LAST;
          rx_state_s = START;
        end else begin
          rx_state_s = IDLE;
        end
      end
      START: begin
        if (rx_cnt_r == CNT_ZERO) begin
          if (rx_sync2_r) begin
            rx_state_s = IDLE;
          end else begin
            rx_cnt_s   = BIT_LAST;
            rx_idx_s   = 3'd0;
            rx_state_s = DATA;
          end
        end else begin
          rx_cnt_s = rx_cnt_r - CNT_ONE;
        end
      end
      DATA: begin
        if (rx_cnt_r == CNT_ZERO) begin
          rx_shift_s = {rx_sync2_r, rx_shift_r[7:1]};
          rx_cnt_s   = BIT_LAST;
          if (rx_idx_r == 3'd7) begin
            rx_state_s = STOP;
          end else begin
            rx_idx_s = rx_idx_r + 3'd1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r - CNT_ONE;
        end
      end
      STOP: begin
        if (rx_cnt_r == CNT_ZERO) begin
          rx_done_s  = 1'b1;
          rx_stop_s  = rx_sync2_r;
          rx_state_s = IDLE;
        end else begin
          rx_cnt_s = rx_cnt_r - CNT_ONE;
        end
      end
      default: begin
        rx_state_s = IDLE;
      end
    endcase
  end

  // RX state register.
  always_ff @(posedge clk100) begin
    if (!reset) begin
      rx_state_r <= IDLE;
      rx_cnt_r   <= CNT_ZERO;
      rx_idx_r   <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_idx_r   <= rx_idx_s;
      rx_shift_r <= rx_shift_s;
    end
  end

  // A port-01 read in the completion cycle frees the holding register in time.
  assign rx_load_s = rx_done_s & rx_stop_s & (~rx_valid_r | rd_data_s);
  assign ovr_set_s = rx_done_s & rx_stop_s & rx_valid_r & ~rd_data_s;
  assign frm_set_s = rx_done_s & ~rx_stop_s;

  // Holding register and sticky flags; set events win over clear-on-read.
  always_ff @(posedge clk100) begin
    if (!reset) begin
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
      framing_r  <= 1'b0;
    end else begin
      if (rx_load_s) begin
        rx_byte_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
      end else if (rd_data_s) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (rd_err_s) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      if (frm_set_s) begin
        framing_r <= 1'b1;
      end else if (rd_err_s) begin
        framing_r <= 1'b0;
      end else begin
        framing_r <= framing_r;
      end
    end
  end

  // Read mux.
  always_comb begin
    IO_read_data = STAT_FALSE;
    if (IO_read_strobe) begin
      case (IO_port_ID)
        PORT_DATA:    IO_read_data = rx_valid_r ? rx_byte_r : STAT_FALSE;
        PORT_RX_STAT: IO_read_data = rx_valid_r ? STAT_TRUE : STAT_FALSE;
        PORT_TX_STAT: IO_read_data = fifo_full_s ? STAT_TRUE : STAT_FALSE;
        PORT_ERR:     IO_read_data = {6'b000000, framing_r, overrun_r};
        default:      IO_read_data = UNMAPPED;
      endcase
    end else begin
      IO_read_data = STAT_FALSE;
    end
  end

endmodule

// File: tb/tb_uart_io_port.sv
// tb_uart_io_port: self-checking bench for uart_io_port at DIV=10.
// A line decoder turns uart_txd back into bytes; a small RX status model
// (valid/byte/overrun/framing) predicts every port read.
`timescale 1ns/1ps
module tb_uart_io_port;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 10_000_000;
  localparam int DIV    = CLK_HZ / BAUD;

  logic       clk100 = 1'b0;
  logic       reset;
  logic [7:0] IO_port_ID;
  logic [7:0] IO_write_data;
  logic       IO_write_strobe;
  logic       IO_read_strobe;
  logic [7:0] IO_read_data;
  logic       uart_rxd;
  logic       uart_txd;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // RX status model
  logic [7:0] m_byte;
  bit         m_valid, m_ovr, m_frm;

  // TX scoreboard
  logic [7:0] tx_exp_q[$];
  logic [7:0] tx_seen_q[$];
  int         tx_start_q[$];
  bit         tx_stop_q[$];

  uart_io_port #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TX_DEPTH(4)) dut (
    .clk100          (clk100),
    .reset           (reset),
    .IO_port_ID      (IO_port_ID),
    .IO_write_data   (IO_write_data),
    .IO_write_strobe (IO_write_strobe),
    .IO_read_strobe  (IO_read_strobe),
    .IO_read_data    (IO_read_data),
    .uart_rxd        (uart_rxd),
    .uart_txd        (uart_txd)
  );

  always #5 clk100 = ~clk100;

  // cycle counter for frame timing
  always @(posedge clk100) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    @(negedge clk100);
    IO_port_ID = port; IO_write_data = data; IO_write_strobe = 1'b1;
    @(posedge clk100); #1;
    IO_write_strobe = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] data);
    @(negedge clk100);
    IO_port_ID = port; IO_read_strobe = 1'b1;
    #1 data = IO_read_data;
    @(posedge clk100); #1;
    IO_read_strobe = 1'b0;
  endtask

  // Read a port and compare against the model, applying the read's side effects.
  task automatic rd_check(input string tag, input logic [7:0] port);
    logic [7:0] got, exp;
    io_read(port, got);
    case (port)
      8'h01: begin exp = m_valid ? m_byte : 8'h00; m_valid = 1'b0; end
      8'h02: exp = m_valid ? 8'hFF : 8'h00;
      8'h04: begin exp = {6'b0, m_frm, m_ovr}; m_frm = 1'b0; m_ovr = 1'b0; end
      default: exp = 8'hFF;
    endcase
    check_eq(tag, got, exp);
  endtask

  // Drive one frame on uart_rxd, leave an idle gap, then update the model.
  task automatic send_rx(input logic [7:0] b, input bit stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk100); uart_rxd = frame[i];
      repeat (DIV - 1) @(negedge clk100);
    end
    @(negedge clk100); uart_rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk100);
    if (!stop_bit) m_frm = 1'b1;
    else if (m_valid) m_ovr = 1'b1;
    else begin m_valid = 1'b1; m_byte = b; end
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (tx_seen_q.size() < n && k < budget) begin
      @(negedge clk100); k++;
    end
    check_eq("tx_frames_arrived", 32'(tx_seen_q.size() >= n), 32'd1);
  endtask

  task automatic pop_tx(input string tag, input logic [7:0] exp, output int start);
    start = 0;
    if (tx_seen_q.size() == 0) begin
      check_eq({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      start = tx_start_q.pop_front();
      check_eq(tag, tx_seen_q.pop_front(), exp);
      check_eq({tag, "_stop"}, tx_stop_q.pop_front(), 1'b1);
    end
  endtask

  function automatic logic exp_line_a5(input int n);
    logic [7:0] v;
    v = 8'hA5;
    if (n == 1) return 1'b1;
    else if (n <= 11) return 1'b0;
    else if (n <= 91) return v[(n - 12) / 10];
    else return 1'b1;
  endfunction

  // Line decoder: detect start, sample mid-bit, record byte, stop and start cycle.
  initial begin : tx_decoder
    logic [7:0] b;
    int st;
    bit sb;
    forever begin
      @(negedge clk100);
      if (uart_txd === 1'b0) begin
        st = cyc;
        repeat (DIV / 2) @(negedge clk100);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk100);
          b[i] = uart_txd;
        end
        repeat (DIV) @(negedge clk100);
        sb = uart_txd;
        tx_seen_q.push_back(b);
        tx_start_q.push_back(st);
        tx_stop_q.push_back(sb);
      end
    end
  end

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] rd, b, b0;
    int t_prev, t_cur, zeros;

    reset = 1'b0; IO_port_ID = 8'h00; IO_write_data = 8'h00;
    IO_write_strobe = 1'b0; IO_read_strobe = 1'b0; uart_rxd = 1'b1;
    m_byte = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_frm = 1'b0;

    // Reset state
    repeat (3) @(negedge clk100);
    #1 check_eq("reset_txd", uart_txd, 1'b1);
    reset = 1'b1;
    rd_check("reset_p01", 8'h01);
    rd_check("reset_p02", 8'h02);
    rd_check("reset_p04", 8'h04);
    io_read(8'h03, rd); check_eq("reset_p03", rd, 8'h00);

    // TX single byte, exact waveform, port 03 held under read
    io_write(8'h01, 8'hA5);
    for (int n = 1; n <= 105; n++) begin
      @(negedge clk100);
      if (n == 1) begin IO_port_ID = 8'h03; IO_read_strobe = 1'b1; end
      #1;
      check_eq($sformatf("a5_line_n%0d", n), uart_txd, exp_line_a5(n));
      check_eq($sformatf("a5_p03_n%0d", n), IO_read_data, 8'h00);
    end
    IO_read_strobe = 1'b0;
    pop_tx("a5_decoded", 8'hA5, t_cur);

    // FIFO full / drop
    for (int i = 1; i <= 5; i++) io_write(8'h01, 8'(i));
    io_read(8'h03, rd); check_eq("fifo_full_after5", rd, 8'hFF);
    io_write(8'h01, 8'h06);
    io_read(8'h03, rd); check_eq("fifo_full_after_drop", rd, 8'hFF);
    wait_tx(5, 800);
    t_prev = 0;
    for (int i = 1; i <= 5; i++) begin
      pop_tx($sformatf("fifo_byte%0d", i), 8'(i), t_cur);
      if (i > 1) check_eq($sformatf("fifo_gap%0d", i), t_cur - t_prev, 32'd101);
      t_prev = t_cur;
    end
    repeat (300) @(negedge clk100);
    check_eq("fifo_no_sixth", tx_seen_q.size(), 32'd0);
    io_read(8'h03, rd); check_eq("fifo_drained_p03", rd, 8'h00);

    // RX + status
    send_rx(8'h3C, 1'b1);
    rd_check("rx_p02_set", 8'h02);
    rd_check("rx_p01_3c", 8'h01);
    rd_check("rx_p02_clr", 8'h02);

    // Overrun, then framing
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd_check("ovr_p01", 8'h01);
    rd_check("ovr_p04_set", 8'h04);
    rd_check("ovr_p04_clr", 8'h04);
    send_rx(8'h96, 1'b0);
    rd_check("frm_p04", 8'h04);
    rd_check("frm_p02", 8'h02);

    // Glitch, unmapped port, strobe low
    @(negedge clk100); uart_rxd = 1'b0;
    repeat (3) @(negedge clk100); uart_rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk100);
    rd_check("glitch_p02", 8'h02);
    rd_check("glitch_p04", 8'h04);
    rd_check("unmapped_07", 8'h07);
    send_rx(8'h5A, 1'b1);
    @(negedge clk100); IO_port_ID = 8'h02; #1;
    check_eq("strobe_low_p02", IO_read_data, 8'h00);
    IO_port_ID = 8'h07; #1;
    check_eq("strobe_low_p07", IO_read_data, 8'h00);
    rd_check("after_strobe_low_p01", 8'h01);

    // Randomized traffic against the models
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          io_read(8'h03, rd);
          check_eq("rnd_p03_encoding", 32'(rd == 8'h00 || rd == 8'hFF), 32'd1);
          if (rd == 8'h00) begin
            b = 8'($urandom);
            io_write(8'h01, b);
            tx_exp_q.push_back(b);
          end
        end
        1: send_rx(8'($urandom), ($urandom_range(0, 5) != 0));
        default: begin
          case ($urandom_range(0, 3))
            0: rd_check("rnd_p01", 8'h01);
            1: rd_check("rnd_p02", 8'h02);
            2: rd_check("rnd_p04", 8'h04);
            default: rd_check("rnd_unmapped", 8'($urandom_range(5, 255)));
          endcase
        end
      endcase
    end
    wait_tx(tx_exp_q.size(), 6000);
    while (tx_exp_q.size() > 0) pop_tx("rnd_tx", tx_exp_q.pop_front(), t_cur);
    rd_check("rnd_final_p01", 8'h01);
    rd_check("rnd_final_p04", 8'h04);

    // Reset mid-frame during TX bit 4 with the FIFO full behind it
    b0 = 8'($urandom);
    io_write(8'h01, b0);
    for (int i = 0; i < 4; i++) io_write(8'h01, 8'($urandom));
    io_read(8'h03, rd); check_eq("rst_prefull_p03", rd, 8'hFF);
    repeat (50) @(negedge clk100);
    #1 check_eq("rst_bit4_before", uart_txd, b0[4]);
    reset = 1'b0;
    @(posedge clk100); #1;
    check_eq("rst_txd_high", uart_txd, 1'b1);
    @(negedge clk100); reset = 1'b1;
    m_valid = 1'b0; m_ovr = 1'b0; m_frm = 1'b0; m_byte = 8'h00;
    io_read(8'h03, rd); check_eq("rst_post_p03", rd, 8'h00);
    rd_check("rst_post_p02", 8'h02);
    rd_check("rst_post_p04", 8'h04);
    zeros = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk100);
      if (uart_txd !== 1'b1) zeros++;
    end
    check_eq("rst_fifo_empty_line_idle", zeros, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
